interrupt_ack_control_8259a: RTL
================================

# interrupt_ack_control_8259a

Sequences the CPU interrupt-acknowledge cycle for the 8259A core. It drives the in-service register's `interrupt`/`latch_in_service`/`end_of_interrupt` inputs and its `priority_rotate` value. It also generates INT, clears the acknowledged IRR bit and places vector/CALL bytes on the data bus. It sits between the priority resolver, the command-word decoder and the in-service register.

## Interface
Parameters: none.

- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- interrupt_acknowledge_n  in  1  INTA level, already synchronized to clock
- u8086_mode  in  1  1 = 8086 (2 pulses), 0 = MCS-80/85 (3 pulses)
- call_address_interval_4  in  1  MCS-80 address interval: 1 = 4, 0 = 8
- auto_eoi_config  in  1  AEOI enable
- rotate_on_aeoi  in  1  rotate priority on AEOI
- vector_base  in  16  8086: [7:3] = T7..T3; MCS-80: A15..A5
- interrupt_pending  in  1  resolver has a winning request
- interrupt  in  8  one-hot winning request
- highest_level_in_service  in  8  one-hot, from in-service register
- eoi_command  in  1  one-cycle OCW2 EOI strobe
- eoi_specific  in  1  1 = specific, 0 = non-specific
- eoi_level  in  3  level for specific EOI
- eoi_rotate  in  1  rotate on this EOI
- interrupt_to_cpu  out  1  INT pin
- latch_in_service  out  1  one-cycle latch pulse
- in_service_set  out  8  captured one-hot level, held
- clear_interrupt_request  out  8  one-cycle IRR clear
- end_of_interrupt  out  8  one-cycle ISR clear mask
- priority_rotate  out  3  lowest-priority level
- data_bus_out  out  8  byte driven during acknowledge
- data_bus_enable  out  1  data bus drive enable

## Operation
- Edge detect: register `interrupt_acknowledge_n` as `inta_prev`, which resets to 1. Fall = prev 1 & cur 0. Rise = prev 0 & cur 1.
- States: IDLE, ACK1, ACK2, ACK3. ACK3 is used only in MCS-80 mode.
- IDLE: `interrupt_to_cpu` follows `interrupt_pending`, registered. A fall does the following:
  - Capture the level in `in_service_set`. If `interrupt_pending`=0, use spurious IR7 (8'h80) and suppress the latch and IRR clear.
  - Deassert INT and enter ACK1.
- ACK1, first pulse:
  - Fall cycle: pulse `latch_in_service` and `clear_interrupt_request`=`in_service_set`.
  - 8086 mode: bus not driven.
  - MCS-80 mode: drive 8'hCD.
  - On rise, go to ACK2.
- ACK2:
  - 8086 mode: drive {vector_base[7:3], level[2:0]}. On rise, go to IDLE.
  - MCS-80 interval 4: drive {vector_base[7:5], level, 2'b00}.
  - MCS-80 interval 8: drive {vector_base[7:6], level, 3'b000}.
  - MCS-80: on rise, go to ACK3.
- ACK3: drive vector_base[15:8]. On rise, go to IDLE.
- AEOI: on the final rise, if `auto_eoi_config`=1 and the acknowledge was not spurious:
  - `end_of_interrupt`=`in_service_set` for one cycle.
  - If `rotate_on_aeoi`=1, `priority_rotate`=level.
- EOI command:
  - Non-specific: mask = `highest_level_in_service`. Specific: mask = one-hot(`eoi_level`).
  - If `eoi_rotate`=1 and the mask is nonzero, `priority_rotate`=bit index of the mask.
  - Mask zero: no clear, no rotate.
- Simultaneous AEOI and EOI command: `end_of_interrupt` is the OR of both masks. The rotate from the EOI command wins.
- A fall in ACK1–ACK3 without a prior rise is impossible from the edge detect and needs no handling. Mode inputs are sampled at IDLE exit and held for the sequence.

## Timing
- All outputs are registered.
- Reset values:
  - State IDLE.
  - `priority_rotate`=3'd7 (IR0 highest).
  - `interrupt_to_cpu`, `latch_in_service`, `data_bus_enable`=0.
  - `in_service_set`, `clear_interrupt_request`, `end_of_interrupt`, `data_bus_out`=0.
- Fall sampled in cycle n: `latch_in_service`/`clear_interrupt_request` are high in cycle n+1 only. `data_bus_enable` rises in n+1.
- Rise sampled in cycle m: `data_bus_enable` is 0 from m+1. The AEOI pulse occurs in m+1.
- EOI strobe in cycle k: `end_of_interrupt` in k+1, `priority_rotate` updated in k+1.
- INT deasserts the cycle after the first fall. It may reassert from the cycle after return to IDLE.
- Reset mid-sequence: IDLE next cycle, bus released, no AEOI issued.

## Structure
- Shared package `pic8259a_pkg` holds:
  - State encoding constants.
  - CALL opcode 8'hCD.
  - `num2bit` (3→8 one-hot) and `bit2num` (one-hot→3) functions, shared with the in-service block.
- Sub-module `eoi_decoder_8259a`: combinational. Maps the EOI command inputs plus `highest_level_in_service` to the mask and rotate value. Kept separate for reuse by the poll-command path.

## Test plan
- Reset, 8086 mode, IR3 pending, vector_base[7:3]=5'b01000:
  - INT=1.
  - Pulse 1: latch pulse, clear=8'h08, bus off.
  - Pulse 2: bus 8'h43.
- MCS-80 mode, interval 4, vector_base=16'h12E0, IR5: bytes 8'hCD, 8'hF4, 8'h12 on pulses 1–3.
- AEOI with rotate, IR2 acknowledged in 8086 mode: `end_of_interrupt`=8'h04 one cycle after the second rise; `priority_rotate`=2.
- Non-specific rotating EOI with `highest_level_in_service`=8'h20: `end_of_interrupt`=8'h20 and `priority_rotate`=5 one cycle after the strobe. With input 8'h00: no change.
- Fall with `interrupt_pending`=0: no latch, no clear; vector uses level 7 (8086 byte {T,3'b111}).
- Reset asserted during ACK2: next cycle bus released, state IDLE, no AEOI pulse, `priority_rotate`=7.

Source files
------------

// File: rtl/pic8259a_pkg.sv
// Shared definitions for the 8259A acknowledge/in-service blocks: sequence
// states, the CALL opcode and one-hot/level conversion helpers.
package pic8259a_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK1 = 2'd1,
        ST_ACK2 = 2'd2,
        ST_ACK3 = 2'd3
    } ack_state_t;

    localparam logic [7:0] CALL_OPCODE    = 8'hCD;
    localparam logic [7:0] SPURIOUS_LEVEL = 8'h80;

    function automatic logic [7:0] num2bit(input logic [2:0] num);
        return 8'b0000_0001 << num;
    endfunction

    // Lowest set bit wins if the input is not strictly one-hot.
    function automatic logic [2:0] bit2num(input logic [7:0] onehot);
        logic [2:0] num;
        num = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (onehot[i]) begin
                num = 3'(i);
            end
        end
        return num;
    endfunction

endpackage

// File: rtl/eoi_decoder_8259a.sv
// Maps an EOI command (specific or non-specific) to the ISR clear mask and the
// resulting lowest-priority level when rotation is requested.
module eoi_decoder_8259a
    import pic8259a_pkg::*;
(
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    input  logic       eoi_rotate,
    input  logic [7:0] highest_level_in_service,
    output logic [7:0] eoi_mask,
    output logic       rotate_valid,
    output logic [2:0] rotate_level
);

    always_comb begin
        eoi_mask     = eoi_specific ? num2bit(eoi_level) : highest_level_in_service;
        rotate_valid = eoi_rotate & (|eoi_mask);
        rotate_level = bit2num(eoi_mask);
    end

endmodule

// File: rtl/interrupt_ack_control_8259a.sv
// INTA sequencer for the 8259A: raises INT, latches the winning level into the
// ISR, drives CALL/vector bytes and issues automatic and commanded EOIs.
module interrupt_ack_control_8259a
    import pic8259a_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        interrupt_acknowledge_n,
    input  logic        u8086_mode,
    input  logic        call_address_interval_4,
    input  logic        auto_eoi_config,
    input  logic        rotate_on_aeoi,
    input  logic [15:0] vector_base,
    input  logic        interrupt_pending,
    input  logic [7:0]  interrupt,
    input  logic [7:0]  highest_level_in_service,
    input  logic        eoi_command,
    input  logic        eoi_specific,
    input  logic [2:0]  eoi_level,
    input  logic        eoi_rotate,
    output logic        interrupt_to_cpu,
    output logic        latch_in_service,
    output logic [7:0]  in_service_set,
    output logic [7:0]  clear_interrupt_request,
    output logic [7:0]  end_of_interrupt,
    output logic [2:0]  priority_rotate,
    output logic [7:0]  data_bus_out,
    output logic        data_bus_enable
);

    ack_state_t  state_q, state_d;
    logic        inta_prev_q;
    logic        int_q, int_d;
    logic        latch_q, latch_d;
    logic [7:0]  isset_q, isset_d;
    logic [7:0]  clear_q, clear_d;
    logic [7:0]  eoi_q, eoi_d;
    logic [2:0]  rot_q, rot_d;
    logic [7:0]  data_q, data_d;
    logic        dbe_q, dbe_d;
    logic        spur_q, spur_d;
    logic        mode8086_q, mode8086_d;
    logic        int4_q, int4_d;
    logic        aeoi_q, aeoi_d;
    logic        rot_aeoi_q, rot_aeoi_d;

    logic        inta_fall, inta_rise;
    logic        aeoi_fire;
    logic [2:0]  level;
    logic [7:0]  vector_byte;
    logic [7:0]  dec_mask;
    logic        dec_rot_valid;
    logic [2:0]  dec_rot_level;

    // Low vector bits are not part of any acknowledge byte.
    logic        unused_vector_bits;
    assign unused_vector_bits = ^vector_base[2:0];

    assign inta_fall = inta_prev_q & ~interrupt_acknowledge_n;
    assign inta_rise = ~inta_prev_q & interrupt_acknowledge_n;
    assign level     = bit2num(isset_q);

    eoi_decoder_8259a u_eoi_decoder (
        .eoi_specific             (eoi_specific),
        .eoi_level                (eoi_level),
        .eoi_rotate               (eoi_rotate),
        .highest_level_in_service (highest_level_in_service),
        .eoi_mask                 (dec_mask),
        .rotate_valid             (dec_rot_valid),
        .rotate_level             (dec_rot_level)
    );

    always_comb begin
        if (mode8086_q) begin
            vector_byte = {vector_base[7:3], level};
        end else if (int4_q) begin
            vector_byte = {vector_base[7:5], level, 2'b00};
        end else begin
            vector_byte = {vector_base[7:6], level, 3'b000};
        end
    end

    always_comb begin
        state_d    = state_q;
        int_d      = int_q;
        latch_d    = 1'b0;
        isset_d    = isset_q;
        clear_d    = 8'h00;
        rot_d      = rot_q;
        data_d     = data_q;
        dbe_d      = dbe_q;
        spur_d     = spur_q;
        mode8086_d = mode8086_q;
        int4_d     = int4_q;
        aeoi_d     = aeoi_q;
        rot_aeoi_d = rot_aeoi_q;
        aeoi_fire  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                int_d = interrupt_pending;
                if (inta_fall) begin
                    isset_d    = interrupt_pending ? interrupt : SPURIOUS_LEVEL;
                    spur_d     = ~interrupt_pending;
                    latch_d    = interrupt_pending;
                    clear_d    = interrupt_pending ? interrupt : 8'h00;
                    int_d      = 1'b0;
                    mode8086_d = u8086_mode;
                    int4_d     = call_address_interval_4;
                    aeoi_d     = auto_eoi_config;
                    rot_aeoi_d = rotate_on_aeoi;
                    dbe_d      = ~u8086_mode;
                    data_d     = u8086_mode ? 8'h00 : CALL_OPCODE;
                    state_d    = ST_ACK1;
                end
            end
            ST_ACK1: begin
                int_d = 1'b0;
                if (inta_rise) begin
                    dbe_d   = 1'b0;
                    data_d  = 8'h00;
                    state_d = ST_ACK2;
                end
            end
            ST_ACK2: begin
                int_d = 1'b0;
                if (inta_fall) begin
                    dbe_d  = 1'b1;
                    data_d = vector_byte;
                end
                if (inta_rise) begin
                    dbe_d  = 1'b0;
                    data_d = 8'h00;
                    if (mode8086_q) begin
                        aeoi_fire = aeoi_q & ~spur_q;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = ST_ACK3;
                    end
                end
            end
            ST_ACK3: begin
                int_d = 1'b0;
                if (inta_fall) begin
                    dbe_d  = 1'b1;
                    data_d = vector_base[15:8];
                end
                if (inta_rise) begin
                    dbe_d     = 1'b0;
                    data_d    = 8'h00;
                    aeoi_fire = aeoi_q & ~spur_q;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        eoi_d = (aeoi_fire ? isset_q : 8'h00) | (eoi_command ? dec_mask : 8'h00);

        // A commanded rotate takes precedence over the automatic one.
        if (eoi_command && dec_rot_valid) begin
            rot_d = dec_rot_level;
        end else if (aeoi_fire && rot_aeoi_q) begin
            rot_d = level;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            inta_prev_q <= 1'b1;
            int_q       <= 1'b0;
            latch_q     <= 1'b0;
            isset_q     <= 8'h00;
            clear_q     <= 8'h00;
            eoi_q       <= 8'h00;
            rot_q       <= 3'd7;
            data_q      <= 8'h00;
            dbe_q       <= 1'b0;
            spur_q      <= 1'b0;
            mode8086_q  <= 1'b0;
            int4_q      <= 1'b0;
            aeoi_q      <= 1'b0;
            rot_aeoi_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            inta_prev_q <= interrupt_acknowledge_n;
            int_q       <= int_d;
            latch_q     <= latch_d;
            isset_q     <= isset_d;
            clear_q     <= clear_d;
            eoi_q       <= eoi_d;
            rot_q       <= rot_d;
            data_q      <= data_d;
            dbe_q       <= dbe_d;
            spur_q      <= spur_d;
            mode8086_q  <= mode8086_d;
            int4_q      <= int4_d;
            aeoi_q      <= aeoi_d;
            rot_aeoi_q  <= rot_aeoi_d;
        end
    end

    assign interrupt_to_cpu        = int_q;
    assign latch_in_service        = latch_q;
    assign in_service_set          = isset_q;
    assign clear_interrupt_request = clear_q;
    assign end_of_interrupt        = eoi_q;
    assign priority_rotate         = rot_q;
    assign data_bus_out            = data_q;
    assign data_bus_enable         = dbe_q;

endmodule
